// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Arbitrates an instruction-fetch port and a load/store data
//               port onto one word-addressed memory controller. Alternating
//               priority on ties, misaligned data accesses are rejected
//               without touching memory, and every output is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
  parameter int MEM_ADDR_BITS = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_sync_reset,
  // instruction fetch port
  input  logic                     i_fetch_req,
  input  logic [MEM_ADDR_BITS+1:0] i_fetch_addr,
  output logic                     o_fetch_ack,
  output logic [31:0]              o_fetch_data,
  // data port
  input  logic                     i_dm_req,
  input  logic                     i_dm_we,
  input  logic [1:0]               i_dm_width,
  input  logic                     i_dm_unsigned,
  input  logic [MEM_ADDR_BITS+1:0] i_dm_addr,
  input  logic [31:0]              i_dm_wdata,
  output logic                     o_dm_ack,
  output logic [31:0]              o_dm_rdata,
  output logic                     o_dm_misaligned,
  // memory controller side
  output logic [MEM_ADDR_BITS-1:0] o_mem_addr,
  output logic                     o_mem_read_en,
  output logic [3:0]               o_mem_write_en,
  output logic [31:0]              o_mem_write_data,
  input  logic [31:0]              i_mem_read_data,
  input  logic                     i_mem_write_ack,
  input  logic                     i_mem_read_ack
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  // Byte lanes and lane-replicated data for a store; {enables, data}.
  function automatic logic [35:0] f_store(input logic [1:0]  width,
                                          input logic [1:0]  a,
                                          input logic [31:0] wd);
    logic [35:0] res;
    case (width)
      2'b00:   res = {4'b0001 << a, {4{wd[7:0]}}};
      2'b01:   res = {(a[1] ? 4'b1100 : 4'b0011), {2{wd[15:0]}}};
      default: res = {4'b1111, wd};
    endcase
    return res;
  endfunction

  // Select the addressed lane(s) of a read word and extend to 32 bits.
  function automatic logic [31:0] f_extract(input logic [31:0] word,
                                            input logic [1:0]  width,
                                            input logic [1:0]  a,
                                            input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (a)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (width)
      2'b00:   res = {{24{~uns & b[7]}}, b};
      2'b01:   res = {{16{~uns & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // state and latched transaction fields
  state_t                   r_state,   w_state;
  logic                     r_last_dm, w_last_dm;
  logic                     r_port_dm, w_port_dm;
  logic                     r_we,      w_we;
  logic [1:0]               r_width,   w_width;
  logic                     r_uns,     w_uns;
  logic [MEM_ADDR_BITS+1:0] r_addr,    w_addr;
  logic [31:0]              r_wdata,   w_wdata;

  // registered outputs
  logic                     r_fetch_ack,      w_fetch_ack;
  logic [31:0]              r_fetch_data,     w_fetch_data;
  logic                     r_dm_ack,         w_dm_ack;
  logic [31:0]              r_dm_rdata,       w_dm_rdata;
  logic                     r_dm_mis,         w_dm_mis;
  logic [MEM_ADDR_BITS-1:0] r_mem_addr,       w_mem_addr;
  logic                     r_mem_read_en,    w_mem_read_en;
  logic [3:0]               r_mem_write_en,   w_mem_write_en;
  logic [31:0]              r_mem_write_data, w_mem_write_data;

  logic                     w_grant_dm;
  logic                     w_misaligned;
  logic [MEM_ADDR_BITS+1:0] w_sel_addr;
  logic [35:0]              w_st_new;
  logic [35:0]              w_st_held;

  // Tie goes to the port that did not win last time.
  assign w_grant_dm   = i_dm_req & (~i_fetch_req | ~r_last_dm);
  assign w_sel_addr   = w_grant_dm ? i_dm_addr : i_fetch_addr;
  assign w_misaligned = ((i_dm_width == 2'b01) & i_dm_addr[0]) |
                        (i_dm_width[1] & (i_dm_addr[1:0] != 2'b00));
  assign w_st_new     = f_store(i_dm_width, i_dm_addr[1:0], i_dm_wdata);
  assign w_st_held    = f_store(r_width, r_addr[1:0], r_wdata);

  // Next state, latched fields and next registered output values.
  always_comb begin
    w_state          = r_state;
    w_last_dm        = r_last_dm;
    w_port_dm        = r_port_dm;
    w_we             = r_we;
    w_width          = r_width;
    w_uns            = r_uns;
    w_addr           = r_addr;
    w_wdata          = r_wdata;
    w_fetch_ack      = 1'b0;
    w_fetch_data     = 32'd0;
    w_dm_ack         = 1'b0;
    w_dm_rdata       = 32'd0;
    w_dm_mis         = 1'b0;
    w_mem_addr       = r_mem_addr;
    w_mem_read_en    = 1'b0;
    w_mem_write_en   = 4'b0000;
    w_mem_write_data = 32'd0;

    case (r_state)
      S_IDLE: begin
        if (i_fetch_req | i_dm_req) begin
          w_port_dm = w_grant_dm;
          if (w_grant_dm & w_misaligned) begin
            // Rejected without any memory strobe.
            w_state  = S_RESP;
            w_dm_ack = 1'b1;
            w_dm_mis = 1'b1;
          end else begin
            w_state    = S_ISSUE;
            w_we       = w_grant_dm & i_dm_we;
            w_width    = w_grant_dm ? i_dm_width : 2'b10;
            w_uns      = w_grant_dm & i_dm_unsigned;
            w_addr     = w_sel_addr;
            w_wdata    = w_grant_dm ? i_dm_wdata : 32'd0;
            w_mem_addr = w_sel_addr[MEM_ADDR_BITS+1:2];
            if (w_grant_dm & i_dm_we) begin
              w_mem_write_en   = w_st_new[35:32];
              w_mem_write_data = w_st_new[31:0];
            end else begin
              w_mem_read_en = 1'b1;
            end
          end
        end
      end

      S_ISSUE: begin
        if (r_we) begin
          if (i_mem_write_ack) begin
            w_state  = S_RESP;
            w_dm_ack = 1'b1;
          end else begin
            w_mem_write_en   = w_st_held[35:32];
            w_mem_write_data = w_st_held[31:0];
          end
        end else begin
          w_state = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (i_mem_read_ack) begin
          w_state = S_RESP;
          if (r_port_dm) begin
            w_dm_ack   = 1'b1;
            w_dm_rdata = f_extract(i_mem_read_data, r_width, r_addr[1:0], r_uns);
          end else begin
            w_fetch_ack  = 1'b1;
            w_fetch_data = i_mem_read_data;
          end
        end
      end

      default: begin
        // S_RESP: ack is visible this cycle; record the winner.
        w_state   = S_IDLE;
        w_last_dm = r_port_dm;
      end
    endcase
  end

  // State, latched fields and outputs; both resets clear everything.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_last_dm        <= 1'b0;
      r_port_dm        <= 1'b0;
      r_we             <= 1'b0;
      r_width          <= 2'b00;
      r_uns            <= 1'b0;
      r_addr           <= '0;
      r_wdata          <= 32'd0;
      r_fetch_ack      <= 1'b0;
      r_fetch_data     <= 32'd0;
      r_dm_ack         <= 1'b0;
      r_dm_rdata       <= 32'd0;
      r_dm_mis         <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_read_en    <= 1'b0;
      r_mem_write_en   <= 4'b0000;
      r_mem_write_data <= 32'd0;
    end else if (i_sync_reset) begin
      r_state          <= S_IDLE;
      r_last_dm        <= 1'b0;
      r_port_dm        <= 1'b0;
      r_we             <= 1'b0;
      r_width          <= 2'b00;
      r_uns            <= 1'b0;
      r_addr           <= '0;
      r_wdata          <= 32'd0;
      r_fetch_ack      <= 1'b0;
      r_fetch_data     <= 32'd0;
      r_dm_ack         <= 1'b0;
      r_dm_rdata       <= 32'd0;
      r_dm_mis         <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_read_en    <= 1'b0;
      r_mem_write_en   <= 4'b0000;
      r_mem_write_data <= 32'd0;
    end else begin
      r_state          <= w_state;
      r_last_dm        <= w_last_dm;
      r_port_dm        <= w_port_dm;
      r_we             <= w_we;
      r_width          <= w_width;
      r_uns            <= w_uns;
      r_addr           <= w_addr;
      r_wdata          <= w_wdata;
      r_fetch_ack      <= w_fetch_ack;
      r_fetch_data     <= w_fetch_data;
      r_dm_ack         <= w_dm_ack;
      r_dm_rdata       <= w_dm_rdata;
      r_dm_mis         <= w_dm_mis;
      r_mem_addr       <= w_mem_addr;
      r_mem_read_en    <= w_mem_read_en;
      r_mem_write_en   <= w_mem_write_en;
      r_mem_write_data <= w_mem_write_data;
    end
  end

  assign o_fetch_ack      = r_fetch_ack;
  assign o_fetch_data     = r_fetch_data;
  assign o_dm_ack         = r_dm_ack;
  assign o_dm_rdata       = r_dm_rdata;
  assign o_dm_misaligned  = r_dm_mis;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_read_en    = r_mem_read_en;
  assign o_mem_write_en   = r_mem_write_en;
  assign o_mem_write_data = r_mem_write_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_arbiter
// Description : Directed and randomized bench for mem_req_arbiter with a
//               behavioural memory responder and reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_sync_reset = 1'b0;
  logic        i_fetch_req = 1'b0;
  logic [17:0] i_fetch_addr = '0;
  logic        o_fetch_ack;
  logic [31:0] o_fetch_data;
  logic        i_dm_req = 1'b0;
  logic        i_dm_we = 1'b0;
  logic [1:0]  i_dm_width = 2'b00;
  logic        i_dm_unsigned = 1'b0;
  logic [17:0] i_dm_addr = '0;
  logic [31:0] i_dm_wdata = '0;
  logic        o_dm_ack;
  logic [31:0] o_dm_rdata;
  logic        o_dm_misaligned;
  logic [15:0] o_mem_addr;
  logic        o_mem_read_en;
  logic [3:0]  o_mem_write_en;
  logic [31:0] o_mem_write_data;
  logic [31:0] i_mem_read_data = 32'hDEAD_BEEF;
  logic        i_mem_write_ack = 1'b0;
  logic        i_mem_read_ack = 1'b0;

  mem_req_arbiter #(.MEM_ADDR_BITS(16)) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_sync_reset     (i_sync_reset),
    .i_fetch_req      (i_fetch_req),
    .i_fetch_addr     (i_fetch_addr),
    .o_fetch_ack      (o_fetch_ack),
    .o_fetch_data     (o_fetch_data),
    .i_dm_req         (i_dm_req),
    .i_dm_we          (i_dm_we),
    .i_dm_width       (i_dm_width),
    .i_dm_unsigned    (i_dm_unsigned),
    .i_dm_addr        (i_dm_addr),
    .i_dm_wdata       (i_dm_wdata),
    .o_dm_ack         (o_dm_ack),
    .o_dm_rdata       (o_dm_rdata),
    .o_dm_misaligned  (o_dm_misaligned),
    .o_mem_addr       (o_mem_addr),
    .o_mem_read_en    (o_mem_read_en),
    .o_mem_write_en   (o_mem_write_en),
    .o_mem_write_data (o_mem_write_data),
    .i_mem_read_data  (i_mem_read_data),
    .i_mem_write_ack  (i_mem_write_ack),
    .i_mem_read_ack   (i_mem_read_ack)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          excl_bad = 0;
  int          stall_left = 0;
  logic [31:0] mem [0:15];
  logic        p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;
  logic [15:0] a0 = '0, a1 = '0, a2 = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle and play the memory controller: read data two cycles
  // after a read strobe, write ack in the strobe cycle unless stalled.
  task automatic tick();
    @(posedge clk);
    #1;
    p2 = p1; p1 = p0; p0 = o_mem_read_en;
    a2 = a1; a1 = a0; a0 = o_mem_addr;
    i_mem_read_ack  = p2;
    i_mem_read_data = p2 ? mem[a2[3:0]] : 32'hDEAD_BEEF;
    if (|o_mem_write_en) begin
      if (stall_left > 0) begin
        i_mem_write_ack = 1'b0;
        stall_left--;
      end else begin
        i_mem_write_ack = 1'b1;
      end
    end else begin
      i_mem_write_ack = 1'b0;
    end
    if (o_mem_read_en && (|o_mem_write_en)) excl_bad++;
  endtask

  // Reference load result computed arithmetically from the word.
  function automatic logic [31:0] ld_model(input logic [31:0] word, input logic [17:0] a,
                                           input logic [1:0] wid, input bit uns);
    logic [31:0] v;
    if (wid >= 2) return word;
    if (wid == 0) begin
      v = (word >> (8 * a[1:0])) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else begin
      v = (word >> (a[1] ? 16 : 0)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end
    return v;
  endfunction

  // One transaction on one port, checked against the model.
  task automatic run_txn(input string tag, input bit dm, input bit we, input logic [1:0] wid,
                         input bit uns, input logic [17:0] addr, input logic [31:0] wd,
                         input int stall);
    int          lat, rd_first, rd_cnt, wr_cnt, elat;
    logic [31:0] data, wdat, word, ewdat;
    logic [15:0] maddr;
    logic [3:0]  wen, ewen;
    bit          mis, other, emis, eread;
    lat = -1; rd_first = -1; rd_cnt = 0; wr_cnt = 0;
    data = 0; wdat = 0; maddr = 0; wen = 0; mis = 0; other = 0;
    word = mem[addr[5:2]];
    stall_left = stall;
    if (dm) begin
      i_dm_req = 1; i_dm_we = we; i_dm_width = wid; i_dm_unsigned = uns;
      i_dm_addr = addr; i_dm_wdata = wd;
    end else begin
      i_fetch_req = 1; i_fetch_addr = addr;
    end
    for (int c = 1; c <= 30 && lat < 0; c++) begin
      tick();
      if (o_mem_read_en) begin
        if (rd_first < 0) rd_first = c;
        rd_cnt++;
        maddr = o_mem_addr;
      end
      if (|o_mem_write_en) begin
        wr_cnt++; wen = o_mem_write_en; wdat = o_mem_write_data; maddr = o_mem_addr;
      end
      if (dm ? o_fetch_ack : o_dm_ack) other = 1;
      if (dm ? o_dm_ack : o_fetch_ack) begin
        lat = c; data = dm ? o_dm_rdata : o_fetch_data; mis = o_dm_misaligned;
      end
    end
    i_fetch_req = 0; i_dm_req = 0;
    tick();
    chk({tag, ".ack_pulse"}, {31'd0, o_fetch_ack | o_dm_ack}, 32'd0);

    emis  = dm && ((wid == 2'b01 && addr[0]) || (wid[1] && addr[1:0] != 2'b00));
    eread = !dm || !we;
    elat  = emis ? 1 : (eread ? 4 : 2 + stall);
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".misaligned"}, {31'd0, mis}, {31'd0, emis});
    chk({tag, ".other_ack"}, {31'd0, other}, 32'd0);
    if (emis) begin
      chk({tag, ".no_strobe"}, rd_cnt + wr_cnt, 0);
      chk({tag, ".data"}, data, 32'd0);
    end else begin
      chk({tag, ".mem_addr"}, {16'd0, maddr}, {16'd0, addr[17:2]});
      if (eread) begin
        chk({tag, ".rd_first"}, rd_first, 1);
        chk({tag, ".rd_cnt"}, rd_cnt, 1);
        chk({tag, ".data"}, data, dm ? ld_model(word, addr, wid, uns) : word);
      end else begin
        case (wid)
          2'b00:   begin ewen = 4'b0001 << addr[1:0]; ewdat = (wd & 32'hFF) * 32'h0101_0101; end
          2'b01:   begin ewen = addr[1] ? 4'b1100 : 4'b0011; ewdat = (wd & 32'hFFFF) * 32'h0001_0001; end
          default: begin ewen = 4'b1111; ewdat = wd; end
        endcase
        chk({tag, ".wen"}, {28'd0, wen}, {28'd0, ewen});
        chk({tag, ".wdata"}, wdat, ewdat);
        chk({tag, ".wr_cycles"}, wr_cnt, stall + 1);
        chk({tag, ".data"}, data, 32'd0);
      end
    end
  endtask

  initial begin
    int         ev_port [0:2];
    int         ev_cyc  [0:2];
    int         nev;
    int         ack_seen;
    logic [31:0] first_dm;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset state
    tick(); tick();
    chk("reset.strobes", {27'd0, o_mem_read_en, o_mem_write_en}, 32'd0);
    chk("reset.acks", {29'd0, o_fetch_ack, o_dm_ack, o_dm_misaligned}, 32'd0);
    chk("reset.mem_addr", {16'd0, o_mem_addr}, 32'd0);
    i_reset = 0;
    tick();

    // Directed cases
    mem[2] = 32'h1234_5678;
    run_txn("fetch_0x8", 0, 0, 2'b10, 0, 18'h0008, 32'h0, 0);
    mem[0] = 32'h80FF_0000;
    run_txn("lb_signed", 1, 0, 2'b00, 0, 18'h0003, 32'h0, 0);
    run_txn("lb_unsigned", 1, 0, 2'b00, 1, 18'h0003, 32'h0, 0);
    run_txn("sh_0x6", 1, 1, 2'b01, 0, 18'h0006, 32'h0000_ABCD, 0);
    run_txn("lw_misalign", 1, 0, 2'b10, 0, 18'h0002, 32'h0, 0);
    mem[3] = 32'h8001_1234;
    run_txn("lh_signed_hi", 1, 0, 2'b01, 0, 18'h000E, 32'h0, 0);
    run_txn("lw_width11", 1, 0, 2'b11, 1, 18'h000C, 32'h0, 0);
    run_txn("sb_stall3", 1, 1, 2'b00, 0, 18'h0011, 32'h1234_56A5, 3);
    run_txn("sh_misalign", 1, 1, 2'b01, 0, 18'h0005, 32'h1111_2222, 0);

    // Both ports held from reset: data, fetch, data
    i_reset = 1;
    tick();
    mem[4] = 32'hCAFE_0004; mem[8] = 32'hBEEF_0008;
    i_fetch_req = 1; i_fetch_addr = 18'h0020;
    i_dm_req = 1; i_dm_we = 0; i_dm_width = 2'b10; i_dm_unsigned = 0; i_dm_addr = 18'h0010;
    i_reset = 0;
    nev = 0; first_dm = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (o_dm_ack && o_fetch_ack) excl_bad++;
      if ((o_dm_ack || o_fetch_ack) && nev < 3) begin
        ev_port[nev] = o_dm_ack ? 1 : 0;
        ev_cyc[nev]  = c;
        if (o_dm_ack && nev == 0) first_dm = o_dm_rdata;
        nev++;
      end
    end
    i_fetch_req = 0; i_dm_req = 0;
    tick(); tick(); tick();
    chk("tie.events", nev, 3);
    if (nev == 3) begin
      chk("tie.port0", ev_port[0], 1);
      chk("tie.cyc0", ev_cyc[0], 4);
      chk("tie.port1", ev_port[1], 0);
      chk("tie.cyc1", ev_cyc[1], 9);
      chk("tie.port2", ev_port[2], 1);
      chk("tie.cyc2", ev_cyc[2], 14);
    end
    chk("tie.dm_data", first_dm, 32'hCAFE_0004);

    // Asynchronous reset while waiting for read data
    mem[1] = 32'h5555_AAAA;
    i_fetch_req = 1; i_fetch_addr = 18'h0004;
    tick(); tick();
    i_reset = 1;
    #1;
    chk("arst.strobes", {27'd0, o_mem_read_en, o_mem_write_en}, 32'd0);
    chk("arst.mem_addr", {16'd0, o_mem_addr}, 32'd0);
    chk("arst.acks", {30'd0, o_fetch_ack, o_dm_ack}, 32'd0);
    i_fetch_req = 0;
    tick();
    i_reset = 0;
    ack_seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (o_fetch_ack || o_dm_ack) ack_seen++;
    end
    chk("arst.late_read_ack", ack_seen, 0);

    // Synchronous reset while a store is stalled
    stall_left = 5;
    i_dm_req = 1; i_dm_we = 1; i_dm_width = 2'b10; i_dm_addr = 18'h0018; i_dm_wdata = 32'h7777_0000;
    tick(); tick();
    chk("srst.before", {28'd0, o_mem_write_en}, 32'hF);
    i_sync_reset = 1;
    tick();
    i_sync_reset = 0; i_dm_req = 0; stall_left = 0;
    chk("srst.wen", {28'd0, o_mem_write_en}, 32'd0);
    chk("srst.mem_addr", {16'd0, o_mem_addr}, 32'd0);
    ack_seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_fetch_ack || o_dm_ack) ack_seen++;
    end
    chk("srst.no_ack", ack_seen, 0);

    // Randomized single-port transactions
    for (int n = 0; n < 40; n++) begin
      bit          r_dm, r_we, r_uns;
      logic [1:0]  r_wid;
      logic [17:0] r_addr;
      logic [31:0] r_wd;
      int          r_stall;
      r_dm    = 1'($urandom_range(0, 1));
      r_we    = 1'($urandom_range(0, 1));
      r_uns   = 1'($urandom_range(0, 1));
      r_wid   = 2'($urandom_range(0, 3));
      r_addr  = 18'($urandom_range(0, 63));
      r_wd    = $urandom;
      r_stall = $urandom_range(0, 2);
      mem[r_addr[5:2]] = $urandom;
      run_txn($sformatf("rnd%0d", n), r_dm, r_we, r_wid, r_uns, r_addr, r_wd, r_stall);
    end

    chk("rw_exclusive", excl_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter MEM_ADDR_BITS, default 16, word-address width of the memory side; byte addresses are MEM_ADDR_BITS+2 wide.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 sync_reset  in  1  synchronous clear, same effect as reset on the next edge.
REQ-005 fetch_req  in  1  instruction read request, held until fetch_ack.
REQ-006 fetch_addr  in  MEM_ADDR_BITS+2  fetch byte address; bits [1:0] ignored.
REQ-007 fetch_ack  out  1  one-cycle completion pulse.
REQ-008 fetch_data  out  32  instruction word, valid with fetch_ack.
REQ-009 dm_req  in  1  data request, held with stable qualifiers until dm_ack.
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_width  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-012 dm_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-013 dm_addr  in  MEM_ADDR_BITS+2  data byte address.
REQ-014 dm_wdata  in  32  store data, right-aligned.
REQ-015 dm_ack  out  1  one-cycle completion pulse.
REQ-016 dm_rdata  out  32  extended load result, valid with dm_ack; 0 for stores.
REQ-017 dm_misaligned  out  1  valid with dm_ack, marks a rejected access.
REQ-018 mem_addr  out  MEM_ADDR_BITS  word address to memory controller.
REQ-019 mem_read_en  out  1  read strobe.
REQ-020 mem_write_en  out  4  byte-lane write enables; bit n = bits [8n+7:8n].
REQ-021 mem_write_data  out  32  lane-aligned store data.
REQ-022 mem_read_data  in  32  memory read word, valid when mem_read_ack = 1.
REQ-023 mem_write_ack  in  1  write accepted in the same cycle.
REQ-024 mem_read_ack  in  1  read data valid; arrives 2 cycles after mem_read_en.

Function
REQ-025 The FSM SHALL have states IDLE, ISSUE, RD_WAIT and RESP, with all outputs registered.
REQ-026 IDLE SHALL grant when either request is high; if both are high, the port not granted last SHALL win; last_grant resets to fetch so data wins the first tie.
REQ-027 A data request is misaligned when half and dm_addr[0] = 1, or word and dm_addr[1:0] != 0.
REQ-028 A misaligned grant SHALL go IDLE->RESP with no memory strobe; RESP drives dm_ack = 1, dm_misaligned = 1, dm_rdata = 0.
REQ-029 On any other grant, the block SHALL latch the address, width, sign, wdata and port, then enter ISSUE.
REQ-030 In ISSUE, mem_addr SHALL equal the latched byte address [MEM_ADDR_BITS+1:2].
REQ-031 For a read in ISSUE, mem_read_en SHALL be 1 for exactly one cycle, then the FSM enters RD_WAIT.
REQ-032 In RD_WAIT, mem_addr SHALL be held; on mem_read_ack = 1, mem_read_data SHALL be captured and the FSM enters RESP.
REQ-033 RD_WAIT has no timeout.
REQ-034 For a store in ISSUE, mem_write_en and mem_write_data SHALL be asserted; the FSM SHALL stay in ISSUE until mem_write_ack = 1, then enter RESP.
REQ-035 Store lanes: byte gives 4'b0001 << a[1:0] with the byte replicated x4; half gives 4'b0011 << (2*a[1]) with the half replicated x2; word gives 4'b1111.
REQ-036 Load extract: byte uses lane a[1:0]; half uses bits [31:16] if a[1] = 1, else [15:0]; word is the full word; extension follows dm_unsigned.
REQ-037 RESP SHALL pulse the granted port's ack for one cycle with its data, then return to IDLE and update last_grant.
REQ-038 The ungranted port's ack SHALL stay 0.
REQ-039 Latency from request sampled in IDLE (cycle 0) SHALL be: read ack at cycle 4; store ack at cycle 2 (immediate mem_write_ack); misaligned ack at cycle 1.
REQ-040 mem_read_en and mem_write_en SHALL never both be active.
REQ-041 Outside ISSUE, mem_write_en SHALL be 0.
REQ-042 A request deasserted before its ack is a protocol violation; the in-flight transaction SHALL still complete.

Reset
REQ-043 On reset or sync_reset: state IDLE, last_grant = fetch, all outputs 0, latched fields 0, any in-flight transaction discarded.
REQ-044 A mem_read_ack arriving after reset SHALL be ignored.

Verification
REQ-045 Fetch read of 0x0008 with mem word 0x1234_5678 -> mem_addr = 2, mem_read_en pulse at cycle 1, fetch_ack at cycle 4 with 0x1234_5678.
REQ-046 Signed byte load at 0x0003 with word 0x80FF_0000 -> dm_rdata = 0xFFFF_FF80; the same load unsigned -> 0x0000_0080.
REQ-047 Half store of 0xABCD at 0x0006 -> mem_addr = 1, mem_write_en = 4'b1100, mem_write_data = 0xABCD_ABCD, dm_ack at cycle 2.
REQ-048 Word load at 0x0002 -> dm_ack with dm_misaligned = 1 at cycle 1, no mem strobe.
REQ-049 fetch_req and dm_req held continuously from reset -> grants alternate data, fetch, data, with the acks interleaved.
REQ-050 reset asserted in RD_WAIT -> outputs 0 immediately; the following mem_read_ack produces no ack.
